// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair. The result is computed
// from latched operands and committed on the last busy cycle, so latency is set purely by the counter.
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic               is_mul, is_div, accept, done;
    logic               mul_signed, wr_hilo;
    logic [2*WIDTH-1:0] prod, acc, res;

    // Sign-extending both operands to 2*WIDTH makes the low 2*WIDTH bits of an
    // unsigned multiply equal to the signed product.
    function automatic logic [2*WIDTH-1:0] mul_prod(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic sgn);
        logic [2*WIDTH-1:0] ax, bx;
        ax = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        bx = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    // Divides magnitudes and restores signs, so most-negative / -1 wraps back to
    // most-negative with a zero remainder. Returns {remainder, quotient}.
    function automatic logic [2*WIDTH-1:0] div_res(input logic [WIDTH-1:0] n,
                                                    input logic [WIDTH-1:0] d,
                                                    input logic sgn);
        logic             neg_q, neg_r;
        logic [WIDTH-1:0] mn, md, q, r;
        neg_r = sgn & n[WIDTH-1];
        neg_q = sgn & (n[WIDTH-1] ^ d[WIDTH-1]);
        mn    = neg_r ? -n : n;
        md    = (sgn & d[WIDTH-1]) ? -d : d;
        if (md == '0) md = {{(WIDTH-1){1'b0}}, 1'b1};
        q = mn / md;
        r = mn % md;
        return {(neg_r ? -r : r), (neg_q ? -q : q)};
    endfunction

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                 (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        accept = (state == IDLE) && start && (is_mul || is_div);
        done   = (state == RUN) && (cnt == CW'(1));
        busy   = (state == RUN);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_r <= op;
            a_r  <= A;
            b_r  <= B;
        end
    end

    always_comb begin
        mul_signed = (op_r == OP_MULT) || (op_r == OP_MADD) || (op_r == OP_MSUB);
        prod       = mul_prod(a_r, b_r, mul_signed);
        acc        = {HI, LO};
        res        = acc;
        wr_hilo    = 1'b0;
        case (op_r)
            OP_MULT, OP_MULTU: begin res = prod;       wr_hilo = 1'b1; end
            OP_MADD, OP_MADDU: begin res = acc + prod; wr_hilo = 1'b1; end
            OP_MSUB, OP_MSUBU: begin res = acc - prod; wr_hilo = 1'b1; end
            OP_DIV, OP_DIVU: begin
                res     = div_res(a_r, b_r, op_r == OP_DIV);
                wr_hilo = (b_r != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            HI  <= '0;
            LO  <= '0;
        end else begin
            if (accept)
                cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            else if (state == RUN)
                cnt <= cnt - CW'(1);

            // Move-to writes only land while idle; a start during RUN is dropped.
            if (done && wr_hilo)
                {HI, LO} <= res;
            else if (state == IDLE && start && op == OP_MTHI)
                HI <= A;
            else if (state == IDLE && start && op == OP_MTLO)
                LO <= A;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: latency, HI/LO results, ignored starts, back-to-back
// issue and asynchronous abort.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns number of busy cycles observed (bounded).
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0; A = 32'hA5A5_A5A5; B = 32'h0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        check("multu_cyc", 64'(n), 64'd5);
        check("multu_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        check("mult_cyc", 64'(n), 64'd5);
        check("mult_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);

        run_op(4'd7, 32'd1, 32'd6, n);
        check("madd_hilo", {HI, LO}, 64'h0);

        run_op(4'd10, 32'd2, 32'd3, n);
        check("msubu_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);

        run_op(4'd8, 32'hFFFF_FFFF, 32'd2, n);
        check("maddu_cyc", 64'(n), 64'd5);
        check("maddu_hilo", {HI, LO}, 64'h0000_0001_FFFF_FFF8);

        run_op(4'd9, 32'hFFFF_FFFF, 32'd3, n);
        check("msub_hilo", {HI, LO}, 64'h0000_0001_FFFF_FFFB);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        check("div_cyc", 64'(n), 64'd10);
        check("div_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("div_ovf_hilo", {HI, LO}, 64'h0000_0000_8000_0000);

        run_op(4'd11, 32'h1111_1111, 32'd5, n);
        check("rsvd_cyc", 64'(n), 64'd0);
        check("rsvd_hilo", {HI, LO}, 64'h0000_0000_8000_0000);

        run_op(4'd4, 32'd100, 32'd7, n);
        check("divu_cyc", 64'(n), 64'd10);
        check("divu_hilo", {HI, LO}, 64'h0000_0002_0000_000E);

        run_op(4'd6, 32'h1234_5678, 32'd0, n);
        check("mtlo_cyc", 64'(n), 64'd0);
        check("mtlo_hilo", {HI, LO}, 64'h0000_0002_1234_5678);

        run_op(4'd5, 32'h0000_BEEF, 32'd0, n);
        check("mthi_hilo", {HI, LO}, 64'h0000_BEEF_1234_5678);

        run_op(4'd4, 32'd7, 32'd0, n);
        check("div0_cyc", 64'(n), 64'd10);
        check("div0_hilo", {HI, LO}, 64'h0000_BEEF_1234_5678);

        // Starts during busy must be dropped.
        op = 4'd2; A = 32'd3; B = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = busy ? 1 : 0;
        @(negedge clk);
        if (busy) n++;
        op = 4'd5; A = 32'h0000_DEAD; start = 1'b1;
        @(negedge clk);
        if (busy) n++;
        op = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("ign_cyc", 64'(n), 64'd5);
        check("ign_hilo", {HI, LO}, 64'h0000_0000_0000_000C);

        run_op(4'd2, 32'd5, 32'd6, n);
        check("b2b_cyc", 64'(n), 64'd5);
        check("b2b_hilo", {HI, LO}, 64'h0000_0000_0000_001E);

        // Abort a divide on busy cycle 4.
        op = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        repeat (3) @(negedge clk);
        check("abort_pre_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_abort", {busy, HI, LO[30:0]}, 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Parametrised multi-cycle multiply/divide unit that sits beside the combinational ALU in the EX stage and owns the HI/LO register pair. It accepts one operation per start pulse and asserts busy for a fixed, op-dependent latency. It commits the result to HI/LO on the final busy cycle. The pipeline stalls any mult/div/mfhi/mflo issued while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (even, at least 8).
MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (at least 1).
DIV_CYCLES, 10, busy cycles for div/divu (at least 1).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  one-cycle request strobe, sampled on rising clk.
op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 treated as none.
A  input  WIDTH  rs operand (multiplicand/dividend/mthi/mtlo source).
B  input  WIDTH  rt operand (multiplier/divisor).
busy  output  1  operation in flight.
HI  output  WIDTH  HI register.
LO  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous): HI=0, LO=0, busy=0, counter=0, FSM to IDLE. Reset asserted mid-operation aborts the operation. No result is written after reset deasserts.
- FSM states: IDLE, RUN.
- IDLE:
  - If start=1 and op is mult-class or div-class at an edge: latch the operands and op, load the counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - busy=1 from the next cycle.
- mthi/mtlo in IDLE: HI (resp. LO) takes A at that edge. No busy, latency 1.
- op none or reserved with start=1: no effect.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0: commit to HI/LO, busy goes 0 on that edge, return to IDLE.
  - busy is high for exactly N cycles, where N is the op latency. The result is visible on HI/LO in the first cycle after busy falls.
- start while busy (any op, including mthi/mtlo): ignored entirely. The in-flight operation is unaffected.
- A new start in the first cycle busy=0: accepted, giving back-to-back ops.
- A/B may change after the start edge. Only the latched values are used.
- mult: signed WIDTH x WIDTH product, 2*WIDTH bits. {HI,LO} = product.
- multu: as mult, but unsigned.
- madd/maddu: {HI,LO} = {HI,LO} + product, modulo 2^(2*WIDTH). Uses HI/LO as they stand at commit time; no intervening write is possible.
- msub/msubu: {HI,LO} = {HI,LO} - product, modulo 2^(2*WIDTH).
- div:
  - Signed; quotient truncates toward zero. LO = quotient, HI = remainder, with the remainder taking the sign of the dividend.
  - Most-negative / -1: LO = most-negative, HI = 0. No trap, no overflow flag.
- divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero (div or divu with B = 0): the full DIV_CYCLES busy period still runs, then HI and LO are left unchanged.
- Implementation choice is free: iterative shift-add/restoring, or a single-cycle result held in a pipeline register. The observable latency must match the parameters exactly.
- No overflow output; all multiply arithmetic wraps.

Test Plan:
- reset, then multu A=0xFFFFFFFF B=0xFFFFFFFF -> busy high exactly 5 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- mult A=0xFFFFFFFE (-2) B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. Then madd A=1 B=6 -> HI=0, LO=0.
- div A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mtlo A=0x12345678, then divu A=7 B=0 -> busy 10 cycles, HI/LO unchanged (LO=0x12345678).
- multu 3x4 started; on cycle 2 of busy, assert start with mthi A=0xDEAD and with div -> both ignored, HI=0, LO=12. A start issued the cycle busy falls is accepted.
- div started; reset pulsed on busy cycle 4 -> busy=0, HI=LO=0 immediately, and remain 0 for 12 cycles after reset release.
